// File: rtl/tx_frm_sync_if.sv
// Engine-side handshake between the TX frame synchroniser and the TX engine.
// master = synchroniser (trig/qw_len/lst_ben/rsk), slave = TX engine (rsk_tk/sync/tx_underrun).
interface tx_frm_sync_if;
    logic        trig;
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;
    logic        rsk;
    logic        rsk_tk;
    logic        sync;
    logic        tx_underrun;

    modport master (
        output trig, qw_len, lst_ben, rsk,
        input  rsk_tk, sync, tx_underrun
    );

    modport slave (
        input  trig, qw_len, lst_ben, rsk,
        output rsk_tk, sync, tx_underrun
    );
endinterface

// File: rtl/tx_frm_sync.sv
// Store-and-forward frame synchroniser in front of the Ethernet TX engine.
// Ports: clk, rst_n (async low); rd_addr/rd_data buffer read port (1-cycle latency);
// committed_prod producer pointer; eng (trig, qw_len, lst_ben, rsk / rsk_tk, sync,
// tx_underrun); len_err sticky length error; frm_cnt completed frame count.
module tx_frm_sync #(
    parameter int BW      = 9,
    parameter int MIN_LEN = 24,
    parameter int MAX_LEN = 9600,
    parameter bit RSK_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [BW:0]   committed_prod,
    tx_frm_sync_if.master eng,
    output logic          len_err,
    output logic [31:0]   frm_cnt
);

    localparam int PW = BW + 1;
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        FETCH, RD_WAIT, DECODE, AVAIL, BUSY, HALT
    } state_t;

    typedef enum logic [1:0] {
        SH_IDLE, SH_WAIT, SH_DEC
    } sh_t;

    state_t        state, state_n;
    sh_t           sh, sh_n;
    logic [BW:0]   ptr, ptr_n;
    logic [BW:0]   sof_ptr, sof_ptr_n;
    logic [12:0]   qw_len, qw_len_n;
    logic [7:0]    lst_ben, lst_ben_n;
    logic [12:0]   nxt_qw, nxt_qw_n;
    logic [7:0]    nxt_ben, nxt_ben_n;
    logic          nxt_valid, nxt_valid_n;
    logic          und, und_n;
    logic          trig, trig_n;
    logic          rsk, rsk_n;
    logic          len_err_n;
    logic [31:0]   frm_cnt_n;
    logic [BW-1:0] rd_addr_n;

    logic [BW:0]   diff;
    logic          has_desc;
    logic [15:0]   len;
    logic [16:0]   len_sum;
    logic          len_ok;
    logic [12:0]   dec_qw;
    logic [7:0]    dec_ben;
    logic          avail_cur;
    logic          avail_nxt;
    logic          und_hit;
    logic          desc_unused;

    assign eng.trig    = trig;
    assign eng.qw_len  = qw_len;
    assign eng.lst_ben = lst_ben;
    assign eng.rsk     = rsk;

    assign desc_unused = ^rd_data[63:16];

    // Occupancy in BW+1 bits; the wrap bit makes a full buffer distinct from empty.
    assign diff      = committed_prod - ptr;
    assign has_desc  = (diff != '0);
    assign len       = rd_data[15:0];
    assign len_sum   = {1'b0, len} + 17'd7;
    assign dec_qw    = 13'(len_sum >> 3);
    assign len_ok    = (len >= MIN_L) && (len <= MAX_L);
    assign dec_ben   = (len[2:0] == 3'd0) ? 8'hFF
                     : (8'h01 << len[2:0]) - 8'h01;
    assign avail_cur = 14'(diff) >= 14'(qw_len) + 14'd1;
    assign avail_nxt = 14'(diff) >= 14'(nxt_qw) + 14'd1;
    assign und_hit   = und | eng.tx_underrun;

    always_comb begin
        state_n     = state;
        sh_n        = sh;
        ptr_n       = ptr;
        sof_ptr_n   = sof_ptr;
        qw_len_n    = qw_len;
        lst_ben_n   = lst_ben;
        nxt_qw_n    = nxt_qw;
        nxt_ben_n   = nxt_ben;
        nxt_valid_n = nxt_valid;
        und_n       = und;
        trig_n      = 1'b0;
        rsk_n       = 1'b0;
        len_err_n   = len_err;
        frm_cnt_n   = frm_cnt;
        rd_addr_n   = rd_addr;

        unique case (state)
            FETCH: begin
                // The descriptor must be committed before it is read.
                if (has_desc) begin
                    rd_addr_n = ptr[BW-1:0];
                    state_n   = RD_WAIT;
                end
            end
            RD_WAIT: state_n = DECODE;
            DECODE: begin
                if (!len_ok) begin
                    len_err_n = 1'b1;
                    state_n   = HALT;
                end else begin
                    qw_len_n  = dec_qw;
                    lst_ben_n = dec_ben;
                    state_n   = AVAIL;
                end
            end
            AVAIL: begin
                if (avail_cur) begin
                    trig_n    = 1'b1;
                    sof_ptr_n = ptr;
                    ptr_n     = ptr + PW'(qw_len) + PW'(1);
                    state_n   = BUSY;
                end
            end
            BUSY: begin
                if (eng.tx_underrun) und_n = 1'b1;

                // Shadow decode of the following descriptor at ptr.
                unique case (sh)
                    SH_IDLE: begin
                        if (!nxt_valid && !len_err && has_desc) begin
                            rd_addr_n = ptr[BW-1:0];
                            sh_n      = SH_WAIT;
                        end
                    end
                    SH_WAIT: sh_n = SH_DEC;
                    SH_DEC: begin
                        sh_n = SH_IDLE;
                        if (len_ok) begin
                            nxt_qw_n    = dec_qw;
                            nxt_ben_n   = dec_ben;
                            nxt_valid_n = 1'b1;
                        end else begin
                            len_err_n = 1'b1;
                        end
                    end
                    default: sh_n = SH_IDLE;
                endcase

                rsk_n = RSK_EN && nxt_valid && avail_nxt
                     && !und_hit && !eng.sync;

                if (eng.sync) begin
                    sh_n        = SH_IDLE;
                    nxt_valid_n = 1'b0;
                    und_n       = 1'b0;
                    if (und_hit) begin
                        // Rewind and resend the aborted frame.
                        ptr_n   = sof_ptr;
                        state_n = AVAIL;
                    end else begin
                        frm_cnt_n = frm_cnt + 32'd1;
                        if (RSK_EN && eng.rsk_tk && nxt_valid) begin
                            qw_len_n  = nxt_qw;
                            lst_ben_n = nxt_ben;
                            sof_ptr_n = ptr;
                            ptr_n     = ptr + PW'(nxt_qw) + PW'(1);
                        end else if (len_err_n) begin
                            state_n = HALT;
                        end else if (nxt_valid) begin
                            qw_len_n  = nxt_qw;
                            lst_ben_n = nxt_ben;
                            state_n   = AVAIL;
                        end else begin
                            state_n = FETCH;
                        end
                    end
                end
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            sh        <= SH_IDLE;
            ptr       <= '0;
            sof_ptr   <= '0;
            qw_len    <= '0;
            lst_ben   <= '0;
            nxt_qw    <= '0;
            nxt_ben   <= '0;
            nxt_valid <= 1'b0;
            und       <= 1'b0;
            trig      <= 1'b0;
            rsk       <= 1'b0;
            len_err   <= 1'b0;
            frm_cnt   <= '0;
            rd_addr   <= '0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            sof_ptr   <= sof_ptr_n;
            qw_len    <= qw_len_n;
            lst_ben   <= lst_ben_n;
            nxt_qw    <= nxt_qw_n;
            nxt_ben   <= nxt_ben_n;
            nxt_valid <= nxt_valid_n;
            und       <= und_n;
            trig      <= trig_n;
            rsk       <= rsk_n;
            len_err   <= len_err_n;
            frm_cnt   <= frm_cnt_n;
            rd_addr   <= rd_addr_n;
        end
    end

endmodule
